nvm_flash_emulator: RTL and testbench



---
 rtl/nvm_flash_emulator.sv | 271 +++++++++++++++++++++++++++
 tb/tb_nvm_flash_emulator.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvm_flash_emulator.sv
// nvm_flash_emulator: device end of the FM_* flash command link.
// Block-RAM word array, one-page write buffer filled by read-modify-write load,
// modelled BUSY timing and page-program commit, STATUS codes for page-protocol errors.
// Build option NVM_PAGELOSS_PROTECT_EN: when defined, a write to a page other than the
// dirty buffered page is rejected (STATUS=01) instead of silently discarding the buffer.
module nvm_flash_emulator #(
   parameter int unsigned MEM_AW       = 10,
   parameter int unsigned PAGE_AW      = 6,
   parameter int unsigned READ_WAIT    = 5,
   parameter int unsigned WRITE_WAIT   = 10,
   parameter int unsigned PROGRAM_WAIT = 850
) (
   input  logic        FM_CLK,
   input  logic        reset,
   input  logic [16:0] FM_ADDR,
   input  logic [15:0] FM_WD,
   input  logic        FM_REN,
   input  logic        FM_WEN,
   input  logic        FM_PROGRAM,
   input  logic        FM_PAGESTATUS,
   output logic [31:0] FM_RD,
   output logic        FM_BUSY,
   output logic [1:0]  FM_STATUS
);

   localparam int unsigned PageIdxW = MEM_AW - PAGE_AW;
   localparam int unsigned MaxRw    = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
   localparam int unsigned MaxWait  = (PROGRAM_WAIT > MaxRw) ? PROGRAM_WAIT : MaxRw;
   localparam int unsigned CntW     = (MaxWait < 2) ? 1 : $clog2(MaxWait + 1);

   localparam logic [1:0] StatOk       = 2'b00;
   localparam logic [1:0] StatReject   = 2'b01;
   localparam logic [1:0] StatNotDirty = 2'b10;
   localparam logic [1:0] StatMismatch = 2'b11;

   typedef enum logic [2:0] {
      StIdle, StRead, StLoad, StWrite, StProgCopy, StProgWait
   } state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [PAGE_AW-1:0]    off_q, off_d;
   logic [MEM_AW-1:0]     addr_q, addr_d;
   logic [15:0]           wd_q, wd_d;
   logic [31:0]           rd_q, rd_d;
   logic [1:0]            status_q, status_d;
   logic [1:0]            res_q, res_d;
   logic                  dirty_q, dirty_d;
   logic [PageIdxW-1:0]   page_idx_q, page_idx_d;
   logic                  pstat_q, pstat_d;

   logic [15:0]           mem_q [2**MEM_AW];
   logic [15:0]           mem_rdata_q;
   logic [MEM_AW-1:0]     ram_raddr;
   logic                  mem_we;

   logic [15:0]           buf_q [2**PAGE_AW];
   logic                  buf_we;
   logic                  ld_v_q;
   logic [PAGE_AW-1:0]    ld_off_q;

   logic [PageIdxW-1:0]   cmd_page;
   logic [PageIdxW-1:0]   addr_page;
   logic [PAGE_AW-1:0]    addr_off;
   logic                  off_last;
   logic [15:0]           rd_word;
   logic [10:0]           pg_ext;
   logic                  unused_addr_hi;

   assign cmd_page       = FM_ADDR[MEM_AW-1:PAGE_AW];
   assign addr_page      = addr_q[MEM_AW-1:PAGE_AW];
   assign addr_off       = addr_q[PAGE_AW-1:0];
   assign off_last       = &off_q;
   assign pg_ext         = 11'(page_idx_q);
   // Upper address bits alias onto the array.
   assign unused_addr_hi = ^FM_ADDR[16:MEM_AW];

   // A dirty buffer holding the addressed page shadows the array.
   assign rd_word = (dirty_q && (addr_page == page_idx_q)) ? buf_q[addr_off] : mem_rdata_q;

   // Synchronous reset gates the copy write so an interrupted commit stops exactly here.
   assign mem_we  = (state_q == StProgCopy) && !reset;

   assign FM_RD     = rd_q;
   assign FM_STATUS = status_q;
   assign FM_BUSY   = (state_q != StIdle);

   // RAM read address: live command address in IDLE, page sweep in LOAD, latched otherwise.
   always_comb begin
      ram_raddr = addr_q;
      case (state_q)
         StIdle:  ram_raddr = FM_ADDR[MEM_AW-1:0];
         StLoad:  ram_raddr = {addr_page, off_q};
         default: ;
      endcase
   end

   // Block-RAM array: one write port for copy-back, registered read port.
   always_ff @(posedge FM_CLK) begin
      if (mem_we) begin
         mem_q[{page_idx_q, off_q}] <= buf_q[off_q];
      end
      mem_rdata_q <= mem_q[ram_raddr];
   end

   // Load pipeline: the buffer word lands two cycles after its RAM address was issued.
   always_ff @(posedge FM_CLK) begin
      if (reset) begin
         ld_v_q   <= 1'b0;
         ld_off_q <= '0;
      end else begin
         ld_v_q   <= (state_q == StLoad);
         ld_off_q <= off_q;
      end
   end

   // Page buffer: load fill first, completing write last so the write wins any overlap.
   always_ff @(posedge FM_CLK) begin
      if (ld_v_q) begin
         buf_q[ld_off_q] <= mem_rdata_q;
      end
      if (buf_we) begin
         buf_q[addr_off] <= wd_q;
      end
   end

   // Control state register.
   always_ff @(posedge FM_CLK) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         off_q      <= '0;
         addr_q     <= '0;
         wd_q       <= '0;
         rd_q       <= '0;
         status_q   <= StatOk;
         res_q      <= StatOk;
         dirty_q    <= 1'b0;
         page_idx_q <= '0;
         pstat_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         off_q      <= off_d;
         addr_q     <= addr_d;
         wd_q       <= wd_d;
         rd_q       <= rd_d;
         status_q   <= status_d;
         res_q      <= res_d;
         dirty_q    <= dirty_d;
         page_idx_q <= page_idx_d;
         pstat_q    <= pstat_d;
      end
   end

   // Command decode, wait counting and completion updates.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      off_d      = off_q;
      addr_d     = addr_q;
      wd_d       = wd_q;
      rd_d       = rd_q;
      status_d   = status_q;
      res_d      = res_q;
      dirty_d    = dirty_q;
      page_idx_d = page_idx_q;
      pstat_d    = pstat_q;
      buf_we     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (FM_REN) begin
               state_d = StRead;
               cnt_d   = CntW'(READ_WAIT);
               addr_d  = FM_ADDR[MEM_AW-1:0];
               pstat_d = 1'b0;
            end else if (FM_WEN) begin
               addr_d = FM_ADDR[MEM_AW-1:0];
               wd_d   = FM_WD;
               res_d  = StatOk;
               if (dirty_q && (cmd_page == page_idx_q)) begin
                  state_d = StWrite;
                  cnt_d   = CntW'(WRITE_WAIT);
               end else begin
`ifdef NVM_PAGELOSS_PROTECT_EN
                  if (dirty_q) begin
                     state_d = StWrite;
                     cnt_d   = CntW'(WRITE_WAIT);
                     res_d   = StatReject;
                  end else begin
                     state_d = StLoad;
                     off_d   = '0;
                  end
`else
                  // Any previously dirty page is dropped here.
                  state_d = StLoad;
                  off_d   = '0;
`endif
               end
            end else if (FM_PROGRAM) begin
               addr_d = FM_ADDR[MEM_AW-1:0];
               if (!dirty_q) begin
                  state_d = StProgWait;
                  cnt_d   = CntW'(PROGRAM_WAIT);
                  res_d   = StatNotDirty;
               end else if (cmd_page == page_idx_q) begin
                  state_d = StProgCopy;
                  off_d   = '0;
                  res_d   = StatOk;
               end else begin
                  state_d = StProgWait;
                  cnt_d   = CntW'(PROGRAM_WAIT);
                  res_d   = StatMismatch;
               end
            end else if (FM_PAGESTATUS) begin
               state_d = StRead;
               cnt_d   = '0;
               pstat_d = 1'b1;
            end
         end
         StRead: begin
            if (cnt_q == '0) begin
               state_d  = StIdle;
               status_d = StatOk;
               rd_d     = pstat_q ? {20'h0, dirty_q, pg_ext} : {16'h0, rd_word};
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StLoad: begin
            off_d = off_q + 1'b1;
            if (off_last) begin
               state_d    = StWrite;
               cnt_d      = CntW'(WRITE_WAIT);
               page_idx_d = addr_page;
               dirty_d    = 1'b1;
            end
         end
         StWrite: begin
            if (cnt_q == '0) begin
               state_d  = StIdle;
               status_d = res_q;
               buf_we   = (res_q == StatOk);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StProgCopy: begin
            off_d = off_q + 1'b1;
            if (off_last) begin
               state_d = StProgWait;
               cnt_d   = CntW'(PROGRAM_WAIT);
            end
         end
         StProgWait: begin
            if (cnt_q == '0) begin
               state_d  = StIdle;
               status_d = res_q;
               if (res_q == StatOk) begin
                  dirty_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_nvm_flash_emulator.sv
// Scoreboard bench for nvm_flash_emulator: expectations are queued as each command is
// issued and popped when the command completes (BUSY falls).
module tb_nvm_flash_emulator;

   localparam int RdBusy  = 5 + 1;
   localparam int PsBusy  = 1;
   localparam int WlBusy  = 64 + 10 + 1;
   localparam int WdBusy  = 10 + 1;
   localparam int PcBusy  = 64 + 850 + 1;
   localparam int PnBusy  = 850 + 1;
   localparam int Limit   = 2000;

   localparam logic [3:0] KRen  = 4'b1000;
   localparam logic [3:0] KWen  = 4'b0100;
   localparam logic [3:0] KProg = 4'b0010;
   localparam logic [3:0] KPs   = 4'b0001;

`ifdef NVM_PAGELOSS_PROTECT_EN
   localparam logic [31:0] PsAfterSwitch = 32'h0000_0001;
`else
   localparam logic [31:0] PsAfterSwitch = 32'h0000_0003;
`endif

   typedef struct {
      logic [3:0]  kind;
      logic [16:0] addr;
      logic [15:0] wd;
      logic        chk_rd;
      logic [31:0] rd;
      logic [1:0]  st;
      int          busy;
   } cmd_t;

   logic        FM_CLK = 1'b0;
   logic        reset;
   logic [16:0] FM_ADDR;
   logic [15:0] FM_WD;
   logic        FM_REN, FM_WEN, FM_PROGRAM, FM_PAGESTATUS;
   logic [31:0] FM_RD;
   logic        FM_BUSY;
   logic [1:0]  FM_STATUS;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_rd_q[$];
   logic [1:0]  exp_st_q[$];
   int          exp_busy_q[$];

   always #5 FM_CLK = ~FM_CLK;

   nvm_flash_emulator dut (
      .FM_CLK        (FM_CLK),
      .reset         (reset),
      .FM_ADDR       (FM_ADDR),
      .FM_WD         (FM_WD),
      .FM_REN        (FM_REN),
      .FM_WEN        (FM_WEN),
      .FM_PROGRAM    (FM_PROGRAM),
      .FM_PAGESTATUS (FM_PAGESTATUS),
      .FM_RD         (FM_RD),
      .FM_BUSY       (FM_BUSY),
      .FM_STATUS     (FM_STATUS)
   );

   // Issue one command, return the outputs at completion and the number of BUSY cycles.
   task automatic do_cmd(input logic [3:0] kind, input logic [16:0] addr, input logic [15:0] wd,
                         output logic [31:0] rd, output logic [1:0] st, output int busy);
      @(posedge FM_CLK); #1;
      {FM_REN, FM_WEN, FM_PROGRAM, FM_PAGESTATUS} = kind;
      FM_ADDR = addr;
      FM_WD   = wd;
      @(posedge FM_CLK); #1;
      {FM_REN, FM_WEN, FM_PROGRAM, FM_PAGESTATUS} = 4'b0000;
      busy = 0;
      while (FM_BUSY === 1'b1 && busy < Limit) begin
         busy++;
         @(posedge FM_CLK); #1;
      end
      if (busy >= Limit) begin
         checks++;
         errors++;
         $display("FAIL timeout cmd=%b addr=%0d: BUSY=%b after %0d cycles, want 0",
                  kind, addr, FM_BUSY, busy);
      end
      rd = FM_RD;
      st = FM_STATUS;
   endtask

   task automatic test_reset();
      cmd_t seq[$];
      logic [31:0] o_rd, e_rd;
      logic [1:0]  o_st, e_st;
      int          o_busy, e_busy;
      reset = 1'b1;
      repeat (3) @(posedge FM_CLK);
      #1;
      checks++;
      if (FM_BUSY !== 1'b0) begin errors++; $display("FAIL reset BUSY: got %b want 0", FM_BUSY); end
      checks++;
      if (FM_RD !== 32'h0) begin errors++; $display("FAIL reset RD: got %h want 0", FM_RD); end
      checks++;
      if (FM_STATUS !== 2'b00) begin
         errors++; $display("FAIL reset STATUS: got %b want 00", FM_STATUS);
      end
      reset = 1'b0;
      seq.push_back('{KPs, 17'd0, 16'h0, 1'b1, 32'h0, 2'b00, PsBusy});
      for (int i = 0; i < seq.size(); i++) begin
         exp_st_q.push_back(seq[i].st);
         exp_busy_q.push_back(seq[i].busy);
         if (seq[i].chk_rd) exp_rd_q.push_back(seq[i].rd);
         do_cmd(seq[i].kind, seq[i].addr, seq[i].wd, o_rd, o_st, o_busy);
         e_st = exp_st_q.pop_front();
         e_busy = exp_busy_q.pop_front();
         checks++;
         if (o_st !== e_st) begin errors++; $display("FAIL reset[%0d] status: got %b want %b", i, o_st, e_st); end
         checks++;
         if (o_busy != e_busy) begin errors++; $display("FAIL reset[%0d] busy: got %0d want %0d", i, o_busy, e_busy); end
         if (seq[i].chk_rd) begin
            e_rd = exp_rd_q.pop_front();
            checks++;
            if (o_rd !== e_rd) begin errors++; $display("FAIL reset[%0d] rd: got %h want %h", i, o_rd, e_rd); end
         end
      end
   endtask

   // Write a whole page with pat|offset, optionally committing it to the array.
   task automatic test_fill_page(input int base, input logic [15:0] pat, input bit commit);
      logic [31:0] o_rd;
      logic [1:0]  o_st, e_st;
      int          o_busy, e_busy;
      for (int i = 0; i < 64 + (commit ? 1 : 0); i++) begin
         exp_st_q.push_back(2'b00);
         if (i == 64) begin
            exp_busy_q.push_back(PcBusy);
            do_cmd(KProg, 17'(base), 16'h0, o_rd, o_st, o_busy);
         end else begin
            exp_busy_q.push_back((i == 0) ? WlBusy : WdBusy);
            do_cmd(KWen, 17'(base + i), pat | 16'(i), o_rd, o_st, o_busy);
         end
         e_st = exp_st_q.pop_front();
         e_busy = exp_busy_q.pop_front();
         checks++;
         if (o_st !== e_st) begin errors++; $display("FAIL fill@%0d[%0d] status: got %b want %b", base, i, o_st, e_st); end
         checks++;
         if (o_busy != e_busy) begin errors++; $display("FAIL fill@%0d[%0d] busy: got %0d want %0d", base, i, o_busy, e_busy); end
      end
   endtask

   task automatic test_write_program(input string tag, input cmd_t seq[$]);
      logic [31:0] o_rd, e_rd;
      logic [1:0]  o_st, e_st;
      int          o_busy, e_busy;
      for (int i = 0; i < seq.size(); i++) begin
         exp_st_q.push_back(seq[i].st);
         exp_busy_q.push_back(seq[i].busy);
         if (seq[i].chk_rd) exp_rd_q.push_back(seq[i].rd);
         do_cmd(seq[i].kind, seq[i].addr, seq[i].wd, o_rd, o_st, o_busy);
         e_st = exp_st_q.pop_front();
         e_busy = exp_busy_q.pop_front();
         checks++;
         if (o_st !== e_st) begin errors++; $display("FAIL %s[%0d] status: got %b want %b", tag, i, o_st, e_st); end
         checks++;
         if (o_busy != e_busy) begin errors++; $display("FAIL %s[%0d] busy: got %0d want %0d", tag, i, o_busy, e_busy); end
         if (seq[i].chk_rd) begin
            e_rd = exp_rd_q.pop_front();
            checks++;
            if (o_rd !== e_rd) begin errors++; $display("FAIL %s[%0d] rd: got %h want %h", tag, i, o_rd, e_rd); end
         end
      end
   endtask

   task automatic test_busy_strobe();
      logic [31:0] e_rd;
      int          n;
      @(posedge FM_CLK); #1;
      FM_REN = 1'b1;
      FM_ADDR = 17'd66;
      exp_rd_q.push_back(32'h0000_FFFF);
      @(posedge FM_CLK); #1;
      FM_REN = 1'b0;
      FM_WEN = 1'b1;
      FM_ADDR = 17'd70;
      FM_WD = 16'h7777;
      n = 0;
      while (FM_BUSY === 1'b1 && n < Limit) begin
         n++;
         if (n == 4) FM_WEN = 1'b0;
         @(posedge FM_CLK); #1;
      end
      FM_WEN = 1'b0;
      e_rd = exp_rd_q.pop_front();
      checks++;
      if (n != RdBusy) begin errors++; $display("FAIL busy_strobe busy: got %0d want %0d", n, RdBusy); end
      checks++;
      if (FM_RD !== e_rd) begin errors++; $display("FAIL busy_strobe rd: got %h want %h", FM_RD, e_rd); end
      @(posedge FM_CLK); #1;
      checks++;
      if (FM_BUSY !== 1'b0) begin errors++; $display("FAIL busy_strobe idle: BUSY got %b want 0", FM_BUSY); end
   endtask

   task automatic test_reset_mid_copy();
      cmd_t seq[$];
      @(posedge FM_CLK); #1;
      FM_PROGRAM = 1'b1;
      FM_ADDR = 17'd128;
      @(posedge FM_CLK); #1;
      FM_PROGRAM = 1'b0;
      checks++;
      if (FM_BUSY !== 1'b1) begin errors++; $display("FAIL midcopy start: BUSY got %b want 1", FM_BUSY); end
      repeat (10) @(posedge FM_CLK);
      #1;
      reset = 1'b1;
      @(posedge FM_CLK); #1;
      reset = 1'b0;
      checks++;
      if (FM_BUSY !== 1'b0) begin errors++; $display("FAIL midcopy reset: BUSY got %b want 0", FM_BUSY); end
      seq.push_back('{KPs, 17'd0, 16'h0, 1'b1, 32'h0, 2'b00, PsBusy});
      for (int i = 0; i < 64; i++) begin
         seq.push_back('{KRen, 17'(128 + i), 16'h0, 1'b1,
                         {16'h0, ((i < 10) ? 16'hB000 : 16'hA000) | 16'(i)}, 2'b00, RdBusy});
      end
      test_write_program("midcopy", seq);
   endtask

   initial begin
      cmd_t seq[$];
      reset = 1'b0;
      FM_ADDR = '0;
      FM_WD = '0;
      {FM_REN, FM_WEN, FM_PROGRAM, FM_PAGESTATUS} = 4'b0000;

      test_reset();
      test_fill_page(64, 16'hFFFF, 1'b1);

      // Clean-page write, buffer/array read mux, page status.
      seq = {};
      seq.push_back('{KWen, 17'd64, 16'h1234, 1'b0, 32'h0, 2'b00, WlBusy});
      seq.push_back('{KRen, 17'd64, 16'h0, 1'b1, 32'h0000_1234, 2'b00, RdBusy});
      seq.push_back('{KRen, 17'd65, 16'h0, 1'b1, 32'h0000_FFFF, 2'b00, RdBusy});
      seq.push_back('{KPs, 17'd0, 16'h0, 1'b1, 32'h0000_0801, 2'b00, PsBusy});
      // Commit and read back from the array.
      seq.push_back('{KProg, 17'd64, 16'h0, 1'b0, 32'h0, 2'b00, PcBusy});
      seq.push_back('{KPs, 17'd0, 16'h0, 1'b1, 32'h0000_0001, 2'b00, PsBusy});
      seq.push_back('{KRen, 17'd64, 16'h0, 1'b1, 32'h0000_1234, 2'b00, RdBusy});
      test_write_program("write_prog", seq);

      // Program protocol errors.
      seq = {};
      seq.push_back('{KProg, 17'd64, 16'h0, 1'b0, 32'h0, 2'b10, PnBusy});
      seq.push_back('{KRen, 17'd64, 16'h0, 1'b1, 32'h0000_1234, 2'b00, RdBusy});
      seq.push_back('{KRen, 17'd65, 16'h0, 1'b1, 32'h0000_FFFF, 2'b00, RdBusy});
      seq.push_back('{KWen, 17'd65, 16'h5555, 1'b0, 32'h0, 2'b00, WlBusy});
      seq.push_back('{KProg, 17'd128, 16'h0, 1'b0, 32'h0, 2'b11, PnBusy});
      seq.push_back('{KPs, 17'd0, 16'h0, 1'b1, 32'h0000_0801, 2'b00, PsBusy});
      test_write_program("prog_err", seq);

      // Write to another page while page 1 is dirty.
      seq = {};
`ifdef NVM_PAGELOSS_PROTECT_EN
      seq.push_back('{KWen, 17'd200, 16'hBEEF, 1'b0, 32'h0, 2'b01, WdBusy});
      seq.push_back('{KRen, 17'd65, 16'h0, 1'b1, 32'h0000_5555, 2'b00, RdBusy});
      seq.push_back('{KRen, 17'd64, 16'h0, 1'b1, 32'h0000_1234, 2'b00, RdBusy});
      seq.push_back('{KPs, 17'd0, 16'h0, 1'b1, 32'h0000_0801, 2'b00, PsBusy});
      seq.push_back('{KProg, 17'd64, 16'h0, 1'b0, 32'h0, 2'b00, PcBusy});
      seq.push_back('{KRen, 17'd65, 16'h0, 1'b1, 32'h0000_5555, 2'b00, RdBusy});
`else
      seq.push_back('{KWen, 17'd200, 16'hBEEF, 1'b0, 32'h0, 2'b00, WlBusy});
      seq.push_back('{KPs, 17'd0, 16'h0, 1'b1, 32'h0000_0803, 2'b00, PsBusy});
      seq.push_back('{KRen, 17'd65, 16'h0, 1'b1, 32'h0000_FFFF, 2'b00, RdBusy});
      seq.push_back('{KRen, 17'd200, 16'h0, 1'b1, 32'h0000_BEEF, 2'b00, RdBusy});
      seq.push_back('{KProg, 17'd200, 16'h0, 1'b0, 32'h0, 2'b00, PcBusy});
      seq.push_back('{KRen, 17'd200, 16'h0, 1'b1, 32'h0000_BEEF, 2'b00, RdBusy});
`endif
      test_write_program("page_switch", seq);

      // Simultaneous strobes: only the highest priority runs; FM_RD holds across PROGRAM.
      seq = {};
      seq.push_back('{KRen | KWen, 17'd66, 16'h7777, 1'b1, 32'h0000_FFFF, 2'b00, RdBusy});
      seq.push_back('{KPs, 17'd0, 16'h0, 1'b1, PsAfterSwitch, 2'b00, PsBusy});
      seq.push_back('{KProg | KPs, 17'd64, 16'h0, 1'b1, PsAfterSwitch, 2'b10, PnBusy});
      test_write_program("priority", seq);

      test_busy_strobe();
      seq = {};
      seq.push_back('{KPs, 17'd0, 16'h0, 1'b1, PsAfterSwitch, 2'b00, PsBusy});
      seq.push_back('{KRen, 17'd70, 16'h0, 1'b1, 32'h0000_FFFF, 2'b00, RdBusy});
      test_write_program("after_strobe", seq);

      test_fill_page(128, 16'hA000, 1'b1);
      test_fill_page(128, 16'hB000, 1'b0);
      test_reset_mid_copy();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
